fetch_redirect_unit: RTL and testbench

//  PC owner and instruction-fetch front end; sink side of the execute-stage jump interface (j_accept/j_wait/j_addr).

---
 rtl/fetch_redirect_unit_pkg.sv | 18 +
 rtl/fetch_redirect_unit_if.sv | 30 +++
 rtl/fetch_redirect_unit_out_buf.sv | 43 ++++
 rtl/fetch_redirect_unit.sv | 109 ++++++++++
 tb/tb_fetch_redirect_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect front end: FSM encoding,
// canonical NOP, default reset PC and a word-align helper.
package fetch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_DRAIN = 2'd2
  } fru_state_e;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Bundle of imem request/response, decode handoff and execute jump signals.
// master = fetch unit, slave = surrounding pipeline / memory.
interface fetch_redirect_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        ex_is_ctrl;
  logic        j_accept;
  logic        j_wait;
  logic [31:0] j_addr;
  logic        flush;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, flush,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready,
           ex_is_ctrl, j_accept, j_wait, j_addr
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, flush,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready,
           ex_is_ctrl, j_accept, j_wait, j_addr
  );
endinterface

// File: rtl/fetch_redirect_unit_out_buf.sv
// One-entry instruction/PC holding register between imem and decode.
// Clear beats load beats consume.
module fetch_out_buf
  import fetch_redirect_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_consume,
  input  logic        i_clear,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Entry state: redirect kills it, a response fills it, decode drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_NOP;
      r_pc    <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC owner and fetch front end: single outstanding imem request, one-entry
// output buffer to decode, redirect on taken jumps with drop of stale data.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter bit          STALL_ON_WAIT = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  fetch_redirect_unit_if.master bus
);

  logic        r_out, r_drop, r_rst_done;
  logic [31:0] r_pc, r_req_pc;
  fru_state_e  r_state, w_state_nxt;

  logic        w_redirect, w_stall, w_req, w_fire, w_rsp, w_load, w_consume;
  logic        w_to_drain;
  logic        w_valid;
  logic [31:0] w_instr, w_pc;

  assign w_redirect = bus.ex_is_ctrl & bus.j_accept & ~bus.j_wait;
  assign w_stall    = STALL_ON_WAIT & bus.ex_is_ctrl & bus.j_wait;
  // r_rst_done keeps req low for the cycle in which reset is released.
  assign w_req      = r_rst_done & ~r_out & ~r_drop & (~w_valid | bus.id_ready)
                    & ~w_stall & ~w_redirect;
  assign w_fire     = w_req & bus.imem_gnt;
  assign w_rsp      = bus.imem_rvalid & r_out;
  assign w_load     = w_rsp & ~r_drop & ~w_redirect;
  assign w_consume  = w_valid & bus.id_ready;
  assign w_to_drain = w_redirect & r_out & ~bus.imem_rvalid;

  // PC, outstanding and drop tracking; redirect overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_out      <= 1'b0;
      r_drop     <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_redirect) begin
        r_pc <= word_align(bus.j_addr);
        if (w_to_drain) begin
          r_drop <= 1'b1;
        end else if (w_rsp) begin
          r_out  <= 1'b0;
          r_drop <= 1'b0;
        end
      end else begin
        if (w_fire) begin
          r_out    <= 1'b1;
          r_req_pc <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
        if (w_rsp) begin
          r_out  <= 1'b0;
          r_drop <= 1'b0;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state: stall tracking, and drain while a killed response is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN, S_STALL: begin
        if (w_to_drain)   w_state_nxt = S_DRAIN;
        else if (w_stall) w_state_nxt = S_STALL;
        else              w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (w_to_drain)            w_state_nxt = S_DRAIN;
        else if (bus.imem_rvalid)  w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  fetch_out_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_instr   (bus.imem_rdata),
    .i_pc      (r_req_pc),
    .i_consume (w_consume),
    .i_clear   (w_redirect),
    .o_valid   (w_valid),
    .o_instr   (w_instr),
    .o_pc      (w_pc)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = w_valid;
  assign bus.if_instr  = w_instr;
  assign bus.if_pc     = w_pc;
  assign bus.flush     = w_redirect;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench: directed phases push expected fetch addresses and decoded
// PCs; a monitor pops and compares on every grant and every decode handoff.
module tb_fetch_redirect_unit;
  import fetch_redirect_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_redirect_unit_if bus ();

  fetch_redirect_unit #(.RESET_PC(32'h0), .STALL_ON_WAIT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int gnt_budget = 0;
  bit rsp_hold = 0, pend = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  assign bus.imem_gnt = (gnt_budget != 0);

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_note(input string name);
    n_chk++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  // imem model: grants while budget lasts, answers one cycle later unless held.
  logic        fire_s;
  logic [31:0] a_s;
  always begin
    @(negedge clk);
    fire_s = bus.imem_req & bus.imem_gnt;
    a_s    = bus.imem_addr;
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0;
    if (fire_s) begin pend = 1'b1; pend_addr = a_s; gnt_budget--; end
    if (pend && !rsp_hold) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memfn(pend_addr);
      pend = 1'b0;
    end
  end

  // Monitor: compare every granted fetch and every decode handoff.
  always @(negedge clk) if (rst_n) begin
    if (bus.imem_req && bus.imem_gnt) begin
      if (exp_addr_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_fetch: got addr %h expected no request", bus.imem_addr);
      end else chk("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
    end
    if (bus.if_valid && bus.id_ready && !bus.flush) begin
      if (exp_pc_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_instr: got pc %h expected none", bus.if_pc);
      end else begin
        logic [31:0] e;
        e = exp_pc_q.pop_front();
        chk("if_pc", bus.if_pc, e);
        chk("if_instr", bus.if_instr, memfn(e));
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_empty(input string name);
    int i = 0;
    while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && i < 60) begin step(); i++; end
    if (exp_addr_q.size() != 0 || exp_pc_q.size() != 0) begin
      fail_note(name);
      exp_addr_q.delete(); exp_pc_q.delete();
    end
  endtask

  task automatic wait_pend(input string name);
    int i = 0;
    while (!pend && i < 30) begin step(); i++; end
    if (!pend) fail_note(name);
  endtask

  task automatic wait_rvalid(input string name);
    int i = 0;
    while (!bus.imem_rvalid && i < 30) begin step(); i++; end
    if (!bus.imem_rvalid) fail_note(name);
  endtask

  task automatic wait_ifvalid(input string name);
    int i = 0;
    while (!bus.if_valid && i < 30) begin step(); i++; end
    if (!bus.if_valid) fail_note(name);
  endtask

  task automatic push(input logic [31:0] a, input bit dec);
    exp_addr_q.push_back(a);
    if (dec) exp_pc_q.push_back(a);
  endtask

  initial begin
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.id_ready = 1'b1; bus.ex_is_ctrl = 1'b0; bus.j_accept = 1'b0;
    bus.j_wait = 1'b0; bus.j_addr = 32'h0;

    // Reset state
    @(negedge clk);
    chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rst_if_instr", bus.if_instr, INSTR_NOP);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_flush", {31'h0, bus.flush}, 32'h0);

    // Sequential fetch 0,4,8
    step();
    push(32'h0, 1); push(32'h4, 1); push(32'h8, 1);
    gnt_budget = 3;
    rst_n = 1'b1;
    wait_empty("seq_fetch_drain");
    @(negedge clk);
    chk("held_req", {31'h0, bus.imem_req}, 32'h1);
    chk("held_addr", bus.imem_addr, 32'hC);

    // Decode backpressure for 5 cycles
    step();
    bus.id_ready = 1'b0;
    push(32'hC, 1); push(32'h10, 1);
    gnt_budget = 2;
    wait_ifvalid("bp_fill");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_if_valid", {31'h0, bus.if_valid}, 32'h1);
      chk("bp_if_pc", bus.if_pc, 32'hC);
      chk("bp_if_instr", bus.if_instr, memfn(32'hC));
      chk("bp_imem_req", {31'h0, bus.imem_req}, 32'h0);
      step();
    end
    bus.id_ready = 1'b1;
    wait_empty("bp_release");

    // Redirect to 0x102 with a request in flight
    push(32'h14, 0);
    gnt_budget = 1; rsp_hold = 1'b1;
    wait_pend("redir_inflight");
    bus.ex_is_ctrl = 1'b1; bus.j_accept = 1'b1; bus.j_addr = 32'h0000_0102;
    @(negedge clk);
    chk("redir_flush", {31'h0, bus.flush}, 32'h1);
    chk("redir_req", {31'h0, bus.imem_req}, 32'h0);
    step();
    bus.ex_is_ctrl = 1'b0; bus.j_accept = 1'b0;
    @(negedge clk);
    chk("redir_flush_pulse", {31'h0, bus.flush}, 32'h0);
    chk("redir_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("redir_drop_req", {31'h0, bus.imem_req}, 32'h0);
    chk("redir_target", bus.imem_addr, 32'h100);
    step();
    push(32'h100, 1); push(32'h104, 1);
    gnt_budget = 2; rsp_hold = 1'b0;
    wait_rvalid("stale_rvalid");
    step();
    @(negedge clk);
    chk("post_drop_req", {31'h0, bus.imem_req}, 32'h1);
    chk("post_drop_addr", bus.imem_addr, 32'h100);
    wait_empty("redir_refetch");

    // j_wait stall for 3 cycles, then accept to 0x40
    push(32'h40, 1);
    bus.ex_is_ctrl = 1'b1; bus.j_wait = 1'b1;
    gnt_budget = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", {31'h0, bus.imem_req}, 32'h0);
      step();
    end
    bus.j_wait = 1'b0; bus.j_accept = 1'b1; bus.j_addr = 32'h40;
    @(negedge clk);
    chk("stall_accept_flush", {31'h0, bus.flush}, 32'h1);
    chk("stall_accept_req", {31'h0, bus.imem_req}, 32'h0);
    step();
    bus.ex_is_ctrl = 1'b0; bus.j_accept = 1'b0;
    @(negedge clk);
    chk("accept_next_req", {31'h0, bus.imem_req}, 32'h1);
    chk("accept_next_addr", bus.imem_addr, 32'h40);
    wait_empty("stall_refetch");

    // PC wrap: redirect to unaligned 0xFFFFFFFF -> 0xFFFFFFFC, then 0
    bus.ex_is_ctrl = 1'b1; bus.j_accept = 1'b1; bus.j_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap_flush", {31'h0, bus.flush}, 32'h1);
    step();
    bus.ex_is_ctrl = 1'b0; bus.j_accept = 1'b0;
    push(32'hFFFF_FFFC, 1); push(32'h0, 1);
    gnt_budget = 2;
    wait_empty("wrap_fetch");
    @(negedge clk);
    chk("wrap_held_addr", bus.imem_addr, 32'h4);

    // Reset with a request outstanding, late response ignored
    step();
    push(32'h4, 0);
    gnt_budget = 1; rsp_hold = 1'b1;
    wait_pend("rst_inflight");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    chk("mid_rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("mid_rst_if_instr", bus.if_instr, INSTR_NOP);
    step();
    rst_n = 1'b1; rsp_hold = 1'b0;
    wait_rvalid("late_rvalid");
    step();
    push(32'h0, 1); push(32'h4, 1);
    gnt_budget = 2;
    wait_empty("restart_fetch");
    @(negedge clk);
    chk("final_held_addr", bus.imem_addr, 32'h8);
    chk("final_if_valid", {31'h0, bus.if_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
